// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC, fetches over a req/ack imem handshake with variable latency,
// and fills the F/D register with stall, flush and in-flight-discard handling.
module fetch_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  PCSrcE,
  input  logic [DATA_WIDTH-1:0] PCTargetE,
  input  logic                  StallD,
  input  logic                  FlushD,
  output logic                  ImemReq,
  output logic [DATA_WIDTH-1:0] ImemAddr,
  input  logic                  ImemAck,
  input  logic [DATA_WIDTH-1:0] ImemRdata,
  output logic [DATA_WIDTH-1:0] InstrD,
  output logic [DATA_WIDTH-1:0] PCD,
  output logic [DATA_WIDTH-1:0] PCPlus4D,
  output logic                  ValidD,
  output logic [DATA_WIDTH-1:0] PCF
);

  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

  typedef enum logic [1:0] {S_FETCH, S_DISCARD, S_HOLD} state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] pc_q, disc_addr_q, buf_q;
  logic [DATA_WIDTH-1:0] instr_q, pcd_q, pcp4_q;
  logic                  valid_q;

  logic [DATA_WIDTH-1:0] target, pc_plus4, fd_word;
  logic                  fd_load;

  assign target   = {PCTargetE[DATA_WIDTH-1:2], 2'b00};
  assign pc_plus4 = pc_q + DATA_WIDTH'(4);

  // An instruction enters F/D only when nothing redirects, squashes or holds it.
  always_comb begin
    fd_load = 1'b0;
    fd_word = ImemRdata;
    case (state_q)
      S_FETCH: fd_load = ImemAck & ~PCSrcE & ~FlushD & ~StallD;
      S_HOLD: begin
        fd_load = ~PCSrcE & ~FlushD & ~StallD;
        fd_word = buf_q;
      end
      default: fd_load = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      disc_addr_q <= '0;
      buf_q       <= '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (ImemAck) begin
            if (PCSrcE) begin
              pc_q <= target;
            end else if (!FlushD) begin
              if (StallD) begin
                buf_q   <= ImemRdata;
                state_q <= S_HOLD;
              end else begin
                pc_q <= pc_plus4;
              end
            end
          end else if (PCSrcE) begin
            // The request in flight must still complete; its data is thrown away.
            disc_addr_q <= pc_q;
            pc_q        <= target;
            state_q     <= S_DISCARD;
          end
        end
        S_DISCARD: begin
          if (PCSrcE) pc_q <= target;
          if (ImemAck) state_q <= S_FETCH;
        end
        S_HOLD: begin
          if (PCSrcE) begin
            pc_q    <= target;
            state_q <= S_FETCH;
          end else if (!StallD) begin
            if (!FlushD) pc_q <= pc_plus4;
            state_q <= S_FETCH;
          end
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= NOP;
      pcd_q   <= '0;
      pcp4_q  <= '0;
    end else if (FlushD) begin
      valid_q <= 1'b0;
      instr_q <= NOP;
    end else if (!StallD) begin
      if (fd_load) begin
        valid_q <= 1'b1;
        instr_q <= fd_word;
        pcd_q   <= pc_q;
        pcp4_q  <= pc_plus4;
      end else begin
        valid_q <= 1'b0;
        instr_q <= NOP;
      end
    end
  end

  assign ImemReq  = ~rst & (state_q != S_HOLD);
  assign ImemAddr = (state_q == S_DISCARD) ? disc_addr_q : pc_q;
  assign InstrD   = instr_q;
  assign PCD      = pcd_q;
  assign PCPlus4D = pcp4_q;
  assign ValidD   = valid_q;
  assign PCF      = pc_q;

endmodule
